// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : request-side state (IDLE, WAIT, KILL)
//   fetch_entry_t : one buffered instruction {pc, ir}
//   NOP_INSTR     : addi x0,x0,0, presented when no instruction is valid
//   align_pc      : force a fetch address onto a word boundary
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer between memory responses and decode.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write one entry (ignored when full unless popping too)
//   pop, dout     : remove the head entry; dout is the head, combinational
//   flush         : empty the buffer; wins over push and pop
//   full, empty   : occupancy flags
//   count         : number of valid entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the pipelined Otter.
// Owns the PC, issues one word fetch at a time over a req/ack/rvalid
// handshake, buffers responses in fetch_fifo and presents them to decode.
//   FE_CLK, FE_RST           : clock, asynchronous active-high reset
//   IMEM_REQ, IMEM_ADDR      : fetch request and its word address
//   IMEM_ACK                 : memory accepted the request
//   IMEM_RVALID, IMEM_RDATA  : in-order response
//   REDIRECT, REDIRECT_PC    : flush and restart at a new PC
//   DE_STALL                 : decode cannot accept this cycle
//   IF_VALID, IF_PC, IF_IR   : instruction presented to decode
//   PERF_FETCHED/PERF_KILLED : delivered / discarded counts, built only
//                              when FETCH_PERF_CNT_EN is defined, else 0
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        FE_CLK,
  input  logic        FE_RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        DE_STALL,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_IR,
  output logic [31:0] PERF_FETCHED,
  output logic [31:0] PERF_KILLED
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int          D  = int'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          room_keep;
  logic          room_push;
  fetch_entry_t  din;
  fetch_entry_t  head;

  assign pop  = !empty && !DE_STALL;
  assign push = (state == WAIT) && IMEM_RVALID && !REDIRECT;
  assign din  = '{pc: req_pc, ir: IMEM_RDATA};

  // Room for a new request after this edge; the request is registered so
  // these look at the occupancy the FIFO will have next cycle.
  assign room_keep = !full || pop;
  assign room_push = (int'(count) + 1 - int'(pop)) < D;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (FE_CLK),
    .rst  (FE_RST),
    .push (push),
    .pop  (pop),
    .flush(REDIRECT),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // pc doubles as the request address: it only advances on ACK, so the
  // address stays stable while a request waits.
  always_ff @(posedge FE_CLK or posedge FE_RST) begin
    if (FE_RST) begin
      state  <= IDLE;
      pc     <= RESET_VECTOR;
      req_pc <= '0;
      req    <= 1'b0;
    end else if (REDIRECT) begin
      pc <= align_pc(REDIRECT_PC);
      unique case (state)
        IDLE: begin
          if (req && IMEM_ACK) begin
            state <= KILL;
            req   <= 1'b0;
          end else begin
            state <= IDLE;
            req   <= 1'b1;
          end
        end
        WAIT, KILL: begin
          // A response landing with the redirect is consumed and dropped.
          if (IMEM_RVALID) begin
            state <= IDLE;
            req   <= 1'b1;
          end else begin
            state <= KILL;
            req   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (req && IMEM_ACK) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
            req    <= 1'b0;
          end else begin
            req <= room_keep;
          end
        end
        WAIT: begin
          if (IMEM_RVALID) begin
            state <= IDLE;
            req   <= room_push;
          end
        end
        KILL: begin
          if (IMEM_RVALID) begin
            state <= IDLE;
            req   <= room_keep;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IMEM_REQ  = req;
  assign IMEM_ADDR = pc;
  assign IF_VALID  = !empty;
  assign IF_PC     = empty ? '0 : head.pc;
  assign IF_IR     = empty ? NOP_INSTR : head.ir;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched;
  logic [31:0] killed;
  logic        kill_evt;

  assign kill_evt = IMEM_RVALID && ((state == KILL) || (state == WAIT && REDIRECT));

  always_ff @(posedge FE_CLK or posedge FE_RST) begin
    if (FE_RST) begin
      fetched <= '0;
      killed  <= '0;
    end else begin
      fetched <= fetched + 32'(pop);
      killed  <= killed + 32'(kill_evt);
    end
  end

  assign PERF_FETCHED = fetched;
  assign PERF_KILLED  = killed;
`else
  assign PERF_FETCHED = '0;
  assign PERF_KILLED  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage with a transaction-level
// reference model (expected-instruction queue plus one outstanding-request
// record). The bench also plays instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        de_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ir;
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;

  fetch_stage #(
    .RESET_VECTOR(RV),
    .DEPTH(DEPTH)
  ) dut (
    .FE_CLK      (clk),
    .FE_RST      (rst),
    .IMEM_REQ    (imem_req),
    .IMEM_ADDR   (imem_addr),
    .IMEM_ACK    (imem_ack),
    .IMEM_RVALID (imem_rvalid),
    .IMEM_RDATA  (imem_rdata),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .DE_STALL    (de_stall),
    .IF_VALID    (if_valid),
    .IF_PC       (if_pc),
    .IF_IR       (if_ir),
    .PERF_FETCHED(perf_fetched),
    .PERF_KILLED (perf_killed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  ent_t        exp_q[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_out_kill;
  logic [31:0] m_out_addr;
  int          m_age;
  logic [31:0] m_fetched;
  logic [31:0] m_killed;
  int unsigned delivered = 0;

  int stall_pct, ack_pct, redir_pct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'(v & 32'd0);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc       = RV;
    m_out      = 0;
    m_out_kill = 0;
    m_out_addr = '0;
    m_age      = 0;
    m_fetched  = '0;
    m_killed   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, RV);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_pc"},   if_pc, 32'h0);
    check({tag, "_ir"},   if_ir, 32'h0000_0013);
    check({tag, "_pf"},   perf_fetched, 32'h0);
    check({tag, "_pk"},   perf_killed, 32'h0);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFC;
      2: return 32'hFFFF_FFF7;
      default: return $urandom;
    endcase
  endfunction

  // One clock: check what the last edge produced, then drive the next edge
  // and advance the reference model by that edge.
  task automatic step();
    logic st, ak, rd, rv;
    logic [31:0] tgt, data;
    @(negedge clk);
    check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("if_pc", if_pc, exp_q[0].pc);
      check("if_ir", if_ir, exp_q[0].ir);
    end
    check("imem_req", 32'(imem_req), 32'(!m_out && exp_q.size() < DEPTH));
    if (imem_req) check("imem_addr", imem_addr, m_pc);
    check("perf_fetched", perf_fetched, exp_perf(m_fetched));
    check("perf_killed", perf_killed, exp_perf(m_killed));

    st   = ($urandom_range(99) < stall_pct);
    ak   = ($urandom_range(99) < ack_pct);
    rd   = ($urandom_range(99) < redir_pct);
    rv   = m_out && m_age >= 1 && ($urandom_range(2) == 0 || m_age >= 3);
    tgt  = pick_target();
    data = rv && m_out_kill ? 32'hDEAD_BEEF : $urandom;
    de_stall    = st;
    imem_ack    = ak;
    redirect    = rd;
    redirect_pc = tgt;
    imem_rvalid = rv;
    imem_rdata  = data;

    if (exp_q.size() != 0 && !st) begin
      void'(exp_q.pop_front());
      m_fetched++;
      delivered++;
    end
    if (rd) begin
      if (m_out && rv) begin
        m_killed++;
        m_out = 0;
      end else if (m_out) begin
        m_out_kill = 1;
      end
      exp_q.delete();
      if (imem_req && ak) begin
        m_out      = 1;
        m_out_kill = 1;
        m_age      = 0;
      end
      m_pc = tgt & ~32'd3;
    end else begin
      if (m_out && rv) begin
        if (m_out_kill) m_killed++;
        else exp_q.push_back('{pc: m_out_addr, ir: data});
        m_out = 0;
      end
      if (imem_req && ak) begin
        m_out      = 1;
        m_out_kill = 0;
        m_out_addr = m_pc;
        m_age      = 0;
        m_pc       = m_pc + 32'd4;
      end
    end
    if (m_out) m_age++;
  endtask

  initial begin
    int cfg[4][3] = '{'{0, 100, 0}, '{10, 90, 3}, '{70, 50, 5}, '{30, 30, 12}};
    int budget;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (cfg[c]) begin
      stall_pct = cfg[c][0];
      ack_pct   = cfg[c][1];
      redir_pct = cfg[c][2];
      repeat (600) step();
    end

    // Reset while a live request is awaiting its response.
    stall_pct = 20; ack_pct = 80; redir_pct = 0;
    budget = 0;
    while (!(m_out && !m_out_kill) && budget < 200) begin
      step();
      budget++;
    end
    check("wait_reached", 32'(m_out && !m_out_kill), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst         = 1'b0;
    redirect    = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    model_reset();
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_rvalid_valid", 32'(if_valid), 32'd0);
    check("late_rvalid_pk", perf_killed, 32'h0);
    repeat (300) step();

    check("progress", 32'(delivered >= 200), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined Otter; sits directly upstream of the decode stage.
- Owns the PC register and issues word fetches to instruction memory over a request/acknowledge/response handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with valid/stall flow control.
- Redirects (branch, jump or trap target) flush the FIFO and restart fetch at a new PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction-buffer entries; legal values 2..8.

Ports:
- FE_CLK  in  1  stage clock; all state updates on posedge.
- FE_RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  word address of the request; bits [1:0] are always 0.
- IMEM_ACK  in  1  memory accepts the request this cycle.
- IMEM_RVALID  in  1  response valid; arrives at least 1 cycle after ACK, in order.
- IMEM_RDATA  in  32  instruction word.
- REDIRECT  in  1  flush and restart fetch.
- REDIRECT_PC  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- DE_STALL  in  1  decode cannot accept this cycle.
- IF_VALID  out  1  IF_IR/IF_PC hold a valid instruction.
- IF_PC  out  32  PC of the presented instruction.
- IF_IR  out  32  presented instruction word.
- PERF_FETCHED  out  32  count of instructions delivered (see Optional Feature).
- PERF_KILLED  out  32  count of responses discarded.

Behaviour:
- Reset values (asynchronous): pc=RESET_VECTOR, FIFO empty, state=IDLE, IMEM_REQ=0, IMEM_ADDR=RESET_VECTOR, IF_VALID=0, IF_PC=0, IF_IR=32'h0000_0013 (NOP), counters=0.
- At most one request is outstanding at a time.
- A request may be issued only when count + outstanding < DEPTH.
- States:
  - IDLE: IMEM_REQ=1, IMEM_ADDR=pc whenever there is FIFO room. On ACK: pc<=pc+4 (wraps mod 2^32), go to WAIT.
  - WAIT: IMEM_REQ=0. On RVALID: push {IMEM_ADDR_latched, IMEM_RDATA}, go to IDLE.
  - KILL: an outstanding response is to be discarded. IMEM_REQ=0. On RVALID: drop the data, increment the kill count, go to IDLE.
- IMEM_REQ and IMEM_ADDR stay stable while waiting for ACK. Request attributes do not change until ACK, except on REDIRECT.
- Output side: IF_VALID = FIFO not empty; IF_PC/IF_IR = head entry, combinational from the FIFO.
  - Pop when IF_VALID && !DE_STALL.
  - Push and pop in the same cycle with the FIFO full is legal: count is unchanged.
  - Latency: RVALID in cycle N gives IF_VALID in cycle N+1 if the FIFO was empty.
- REDIRECT (highest priority, same cycle):
  - FIFO cleared and pc<=REDIRECT_PC & ~3.
  - If state is WAIT, or a response is in flight, go to KILL.
  - A request that is ACKed in the redirect cycle is also killed.
  - IF_VALID=0 in the following cycle.
  - REDIRECT in KILL keeps KILL and overwrites pc.
- RVALID arriving in the same cycle as REDIRECT: data dropped, go to IDLE, kill count incremented.
- DE_STALL never blocks a redirect.
- RVALID while in IDLE is a protocol error: ignored.
- Reset mid-transaction: all state clears. A late RVALID after reset is treated as a protocol error and ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: PERF_FETCHED increments on each pop; PERF_KILLED increments on each discarded response. Both are 32-bit, wrap, and clear only on FE_RST.
- Undefined: no counter flops are built and both ports are tied to 0.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, WAIT, KILL}; NOP_INSTR=32'h0000_0013; fetch_entry_t struct {pc[31:0], ir[31:0]}.
- Sub-module fetch_fifo: parameterised DEPTH, stores fetch_entry_t, ports push/pop/flush/full/empty/count, flush has priority over push.

Test Plan:
- Reset release with IMEM_ACK=1 and RVALID one cycle later, words 0x00500093, 0x00100113 → IF_PC 0x0, 0x4 with matching IF_IR; IMEM_ADDR sequence 0x0, 0x4, 0x8.
- DE_STALL=1 for 6 cycles → exactly DEPTH=2 entries fetched, then IMEM_REQ=0. Release stall → entries pop in order and fetch resumes at 0x8.
- REDIRECT to 0x103 while in WAIT → next IMEM_ADDR=0x100. The stale RVALID (0xDEADBEEF) never appears on IF_IR; PERF_KILLED=1 with the macro defined.
- REDIRECT and RVALID in the same cycle, FIFO holding 1 entry → IF_VALID=0 next cycle; first new IF_PC=REDIRECT_PC.
- IMEM_ACK held low for 5 cycles → IMEM_ADDR and IMEM_REQ stable throughout; no pc advance.
- PC at 0xFFFF_FFFC → next request address 0x0000_0000. Assert FE_RST during WAIT → all outputs return to their reset values immediately.
